// File: rtl/cv32e40p_lce_alarm_handler.sv
// -----------------------------------------------------------------------------
// cv32e40p_lce_alarm_handler
//
// Purpose:
//   Consumes the level alarm of the LCE detector. The alarm is debounced over
//   FILTER_CYCLES consecutive samples. A qualified alarm is an "event": it
//   bumps a saturating event counter and raises an interrupt request that is
//   held until the controller acknowledges it. After the acknowledge the
//   detector is re-armed with a one-cycle init pulse. Once MAX_ALARMS events
//   have been counted the block escalates to a sticky lock that only rst
//   releases.
//
// Optional feature (macro LCE_ALARM_TIMEOUT_EN):
//   When defined, a request left unacknowledged for ACK_TIMEOUT cycles
//   escalates to the lock. When undefined, the request waits indefinitely and
//   ACK_TIMEOUT only takes part in the parameter sanity check.
//
// Ports:
//   clk              clock, rising edge
//   rst              asynchronous active-high reset
//   enable_i         gates alarm filtering; low clears the filter
//   alarm_i          level alarm from the detector
//   irq_ack_i        controller acknowledge of irq_o
//   clear_cnt_i      software clear of the event counter
//   irq_o            alarm interrupt request
//   detector_init_o  one-cycle re-arm pulse to the detector
//   lock_o           sticky core lock request
//   alarm_cnt_o      event count, CNT_W = $clog2(MAX_ALARMS+1) bits
//
// All outputs are decoded from registers only.
// -----------------------------------------------------------------------------
module cv32e40p_lce_alarm_handler #(
    parameter int FILTER_CYCLES = 2,
    parameter int MAX_ALARMS    = 3,
    parameter int ACK_TIMEOUT   = 16,
    localparam int CNT_W        = $clog2(MAX_ALARMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             alarm_i,
    input  logic             irq_ack_i,
    input  logic             clear_cnt_i,
    output logic             irq_o,
    output logic             detector_init_o,
    output logic             lock_o,
    output logic [CNT_W-1:0] alarm_cnt_o
);

    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

    if (FILTER_CYCLES < 1 || MAX_ALARMS < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
        $error("cv32e40p_lce_alarm_handler: FILTER_CYCLES, MAX_ALARMS and ACK_TIMEOUT must be >= 1");
    end

    // Every 2-bit code is a named state; the default arm below still maps any
    // corrupted value to LOCKED so the block fails secure.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REQ    = 2'b01,
        ST_REARM  = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              event_hit;

    // Increment that sticks at MAX_ALARMS instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] base);
        logic [CNT_W:0] sum;
        sum = {1'b0, base} + (CNT_W + 1)'(1);
        if (sum >= (CNT_W + 1)'(MAX_ALARMS)) begin
            return CNT_W'(MAX_ALARMS);
        end
        return sum[CNT_W-1:0];
    endfunction

`ifdef LCE_ALARM_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

    // Counts unacknowledged REQ cycles; restarts on every REQ entry. The
    // escalation to LOCKED at ACK_TIMEOUT-1 keeps it from ever wrapping.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q != ST_REQ && state_d == ST_REQ) begin
            tmo_d = '0;
        end else if (state_q == ST_REQ && !irq_ack_i) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        filt_d    = '0;
        cnt_d     = cnt_q;
        event_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (alarm_i && enable_i) begin
                    if (filt_q == FILT_W'(FILTER_CYCLES - 1)) begin
                        event_hit = 1'b1;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
                end
                // A clear on the trigger edge is applied before the increment.
                if (event_hit) begin
                    cnt_d   = sat_inc(clear_cnt_i ? '0 : cnt_q);
                    state_d = (cnt_d == CNT_W'(MAX_ALARMS)) ? ST_LOCKED : ST_REQ;
                end else if (clear_cnt_i) begin
                    cnt_d = '0;
                end
            end

            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d = ST_REARM;
`ifdef LCE_ALARM_TIMEOUT_EN
                end else if (tmo_hit) begin
                    state_d = ST_LOCKED;
`endif
                end
                if (clear_cnt_i) begin
                    cnt_d = '0;
                end
            end

            ST_REARM: begin
                state_d = ST_IDLE;
                if (clear_cnt_i) begin
                    cnt_d = '0;
                end
            end

            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end

            default: begin
                state_d = ST_LOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            filt_q  <= '0;
            cnt_q   <= '0;
`ifdef LCE_ALARM_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
`ifdef LCE_ALARM_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign irq_o           = (state_q == ST_REQ) || (state_q == ST_LOCKED);
    assign detector_init_o = (state_q == ST_REARM);
    assign lock_o          = (state_q == ST_LOCKED);
    assign alarm_cnt_o     = cnt_q;

endmodule

// File: tb/tb_cv32e40p_lce_alarm_handler.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_lce_alarm_handler
//
// Scoreboard bench. The stimulus process drives inputs on the falling edge,
// advances a behavioural model for the coming rising edge and queues the
// outputs the block should show afterwards. A monitor samples the outputs
// shortly after every rising edge and compares them with the queue head.
// The model tracks the alarm as a run length of consecutive qualified samples
// and the handler as a set of flags (pending request, re-arm, locked).
// -----------------------------------------------------------------------------
module tb_cv32e40p_lce_alarm_handler;

    localparam int FILTER_CYCLES = 2;
    localparam int MAX_ALARMS    = 3;
    localparam int ACK_TIMEOUT   = 16;
    localparam int CNT_W         = $clog2(MAX_ALARMS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable_i = 1'b0;
    logic             alarm_i = 1'b0;
    logic             irq_ack_i = 1'b0;
    logic             clear_cnt_i = 1'b0;
    logic             irq_o;
    logic             detector_init_o;
    logic             lock_o;
    logic [CNT_W-1:0] alarm_cnt_o;

    cv32e40p_lce_alarm_handler #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .MAX_ALARMS   (MAX_ALARMS),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable_i),
        .alarm_i        (alarm_i),
        .irq_ack_i      (irq_ack_i),
        .clear_cnt_i    (clear_cnt_i),
        .irq_o          (irq_o),
        .detector_init_o(detector_init_o),
        .lock_o         (lock_o),
        .alarm_cnt_o    (alarm_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             irq;
        logic             init;
        logic             lock;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    started = 1'b0;
    bit    done = 1'b0;
    string phase = "reset";

    // Behavioural model state
    bit m_req, m_rearm, m_locked;
    int m_streak, m_count;
`ifdef LCE_ALARM_TIMEOUT_EN
    int m_req_cycles;
`endif

    function automatic obs_t dut_obs();
        obs_t o;
        o.irq  = irq_o;
        o.init = detector_init_o;
        o.lock = lock_o;
        o.cnt  = alarm_cnt_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.irq  = m_req || m_locked;
        o.init = m_rearm;
        o.lock = m_locked;
        o.cnt  = CNT_W'(m_count);
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] t=%0t: got irq=%0b init=%0b lock=%0b cnt=%0d, expected irq=%0b init=%0b lock=%0b cnt=%0d",
                     name, phase, $time, act.irq, act.init, act.lock, act.cnt,
                     exp.irq, exp.init, exp.lock, exp.cnt);
        end
    endtask

    task automatic model_reset();
        m_req    = 1'b0;
        m_rearm  = 1'b0;
        m_locked = 1'b0;
        m_streak = 0;
        m_count  = 0;
`ifdef LCE_ALARM_TIMEOUT_EN
        m_req_cycles = 0;
`endif
    endtask

    // Effect of one rising edge with reset released.
    task automatic model_step(input bit a, input bit e, input bit k, input bit c);
        int nc;
        if (m_locked) return;
        if (m_rearm) begin
            m_rearm = 1'b0;
            m_streak = 0;
            if (c) m_count = 0;
            return;
        end
        if (m_req) begin
            if (c) m_count = 0;
            if (k) begin
                m_req   = 1'b0;
                m_rearm = 1'b1;
            end else begin
`ifdef LCE_ALARM_TIMEOUT_EN
                m_req_cycles++;
                if (m_req_cycles == ACK_TIMEOUT) begin
                    m_req    = 1'b0;
                    m_locked = 1'b1;
                end
`endif
            end
            return;
        end
        if (a && e) m_streak++;
        else        m_streak = 0;
        if (m_streak == FILTER_CYCLES) begin
            m_streak = 0;
            nc = (c ? 0 : m_count) + 1;
            if (nc > MAX_ALARMS) nc = MAX_ALARMS;
            m_count = nc;
            if (nc == MAX_ALARMS) begin
                m_locked = 1'b1;
            end else begin
                m_req = 1'b1;
`ifdef LCE_ALARM_TIMEOUT_EN
                m_req_cycles = 0;
`endif
            end
        end else if (c) begin
            m_count = 0;
        end
    endtask

    task automatic cyc(input bit a, input bit e, input bit k, input bit c);
        @(negedge clk);
        rst         = 1'b0;
        alarm_i     = a;
        enable_i    = e;
        irq_ack_i   = k;
        clear_cnt_i = c;
        model_step(a, e, k, c);
        exp_q.push_back(model_obs());
        started = 1'b1;
    endtask

    // Asserts rst mid-cycle, checks that the outputs drop without a clock
    // edge, then holds reset across one rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        alarm_i     = 1'b0;
        enable_i    = 1'b0;
        irq_ack_i   = 1'b0;
        clear_cnt_i = 1'b0;
        #1;
        compare("async_reset", dut_obs(), obs_t'(0));
        model_reset();
        exp_q.push_back(model_obs());
        started = 1'b1;
    endtask

    task automatic event_and_ack();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare("scoreboard", dut_obs(), exp_q.pop_front());
            end else if (started && !done) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty [%s] t=%0t: got no expected entry, expected one per cycle",
                         phase, $time);
            end
        end
    end

    // Stimulus
    initial begin
        bit a;
        model_reset();
        do_reset();

        phase = "filter_reject";
        repeat (10) begin
            cyc(1, 1, 0, 0);
            cyc(0, 1, 0, 0);
        end

        phase = "nominal";
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);

        phase = "escalate";
        event_and_ack();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(i[0], i[1], 1, 1);

        phase = "collision";
        do_reset();
        event_and_ack();
        event_and_ack();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);

        phase = "reset_mid_req";
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);

`ifdef LCE_ALARM_TIMEOUT_EN
        phase = "timeout_lock";
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (ACK_TIMEOUT + 2) cyc(0, 1, 0, 0);

        phase = "timeout_ack_wins";
        do_reset();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (ACK_TIMEOUT - 1) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
`endif

        phase = "random";
        do_reset();
        a = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) a = ~a;
                cyc(a,
                    $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 31) == 0);
            end
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
